multicycle_controller: RTL and testbench

//  Control unit for the multicycle ARM datapath: Moore FSM sequencing fetch/decode/execute/writeback over
//  one shared memory and ALU, plus registered NZCV flags and condition-code gating. Sits beside the

---
 rtl/arm_ctrl_pkg.sv | 54 +++++
 rtl/cond_logic.sv | 69 ++++++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared types and select encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    // Ten live states; encodings 10..15 are unused and recover to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// Flags register, condition check and gating of the architectural write enables.
module cond_logic
    import arm_ctrl_pkg::*;
#(
    parameter logic NV_EXECUTES = 1'b0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic [1:0] i_flag_w,
    input  logic       i_pcs,
    input  logic       i_next_pc,
    input  logic       i_reg_w,
    input  logic       i_mem_w,
    input  logic       i_en,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic       o_mem_write
);

    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic [1:0] w_flag_write;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluate the condition field against the registered NZCV flags.
    always_comb begin
        w_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = ~(w_n ^ w_v);
            COND_LT: w_cond_ex = w_n ^ w_v;
            COND_GT: w_cond_ex = ~w_z & ~(w_n ^ w_v);
            COND_LE: w_cond_ex = w_z | (w_n ^ w_v);
            COND_AL: w_cond_ex = 1'b1;
            COND_NV: w_cond_ex = NV_EXECUTES;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_write = i_flag_w & {2{w_cond_ex & i_en}};

    // NZ and CV halves load independently so logical ops keep C and V.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_flag_write[1]) r_flags[3:2] <= i_alu_flags[3:2];
            if (w_flag_write[0]) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign o_pc_write  = i_en & (i_next_pc | (i_pcs & w_cond_ex));
    assign o_reg_write = i_en & i_reg_w & w_cond_ex;
    assign o_mem_write = i_en & i_mem_w & w_cond_ex;

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM, ALU decoder and instruction-field decode for the multicycle ARM datapath.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [3:0] PC_REG      = 4'd15,
    parameter logic       NV_EXECUTES = 1'b0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_next_pc, w_reg_w, w_mem_w, w_branch, w_ir_write, w_alu_op, w_legal;
    logic       w_en, w_pcs;
    logic [1:0] w_flag_w;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state and per-state control outputs.
    always_comb begin
        w_next_state = S_FETCH;
        w_next_pc    = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_alu_op     = 1'b0;
        w_legal      = 1'b1;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RD2;
        case (r_state)
            S_FETCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                w_ir_write   = 1'b1;
                w_next_pc    = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (Op)
                    OP_MEM:    w_next_state = S_MEMADR;
                    OP_DP:     w_next_state = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BRANCH: w_next_state = S_BRANCH;
                    default:   w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB      = SRCB_EXTIMM;
                w_next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                w_reg_w   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                w_mem_w = 1'b1;
            end
            S_EXECR: begin
                w_alu_op     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB      = SRCB_EXTIMM;
                w_alu_op     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_w = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                w_branch  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ALU decoder: only the four supported commands may set flags.
    always_comb begin
        ALUControl = ALU_ADD;
        w_flag_w   = 2'b00;
        if (w_alu_op) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = ALU_ADD; w_flag_w = {Funct[0], Funct[0]}; end
                4'b0010: begin ALUControl = ALU_SUB; w_flag_w = {Funct[0], Funct[0]}; end
                4'b0000: begin ALUControl = ALU_AND; w_flag_w = {Funct[0], 1'b0}; end
                4'b1100: begin ALUControl = ALU_ORR; w_flag_w = {Funct[0], 1'b0}; end
                default: begin ALUControl = ALU_ADD; w_flag_w = 2'b00; end
            endcase
        end
    end

    assign ImmSrc  = Op;
    assign RegSrc  = {Op == OP_MEM, Op == OP_BRANCH};
    assign w_pcs   = ((Rd == PC_REG) & w_reg_w) | w_branch;
    assign w_en    = w_legal & ~reset;
    assign IRWrite = w_ir_write & w_en;

    cond_logic #(
        .NV_EXECUTES (NV_EXECUTES)
    ) u_cond_logic (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (Cond),
        .i_alu_flags (ALUFlags),
        .i_flag_w    (w_flag_w),
        .i_pcs       (w_pcs),
        .i_next_pc   (w_next_pc),
        .i_reg_w     (w_reg_w),
        .i_mem_w     (w_mem_w),
        .i_en        (w_en),
        .o_pc_write  (PCWrite),
        .o_reg_write (RegWrite),
        .o_mem_write (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against an instruction-level model.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [15:0] w_got;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] m_flags;

    typedef enum int {K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB,
                      K_MEMWRITE, K_EXECR, K_EXECI, K_ALUWB, K_BRANCH} kind_t;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
    );

    assign w_got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // ARM condition semantics over {N,Z,C,V}; Cond=1111 never executes.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00:   return 4;
            2'b01:   return f[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic kind_t step_of(input logic [1:0] op, input logic [5:0] f, input int i);
        if (i == 0) return K_FETCH;
        if (i == 1) return K_DECODE;
        case (op)
            2'b00:   return (i == 2) ? (f[5] ? K_EXECI : K_EXECR) : K_ALUWB;
            2'b01:   if (i == 2) return K_MEMADR;
                     else if (!f[0]) return K_MEMWRITE;
                     else return (i == 3) ? K_MEMREAD : K_MEMWB;
            default: return K_BRANCH;
        endcase
    endfunction

    // Command code of a supported DP op, or -1 when unsupported.
    function automatic int dp_cmd(input logic [5:0] f);
        case (f[4:1])
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] exp_outputs(input kind_t k, input logic [3:0] c,
                                                input logic [1:0] op, input logic [5:0] f,
                                                input logic [3:0] rd, input logic [3:0] flags,
                                                input bit rst);
        bit ce = cond_ok(c, flags);
        logic pcw = 0, mw = 0, rw = 0, irw = 0, adr = 0, srca = 0;
        logic [1:0] res = 0, srcb = 0, alu = 0;
        case (k)
            K_FETCH:    begin srca = 1; srcb = 2; res = 2; irw = 1; pcw = 1; end
            K_DECODE:   begin srca = 1; srcb = 2; res = 2; end
            K_MEMADR:   srcb = 1;
            K_MEMREAD:  adr = 1;
            K_MEMWB:    begin res = 1; rw = ce; pcw = (rd == 4'd15) && ce; end
            K_MEMWRITE: begin adr = 1; mw = ce; end
            K_EXECR:    alu = (dp_cmd(f) < 0) ? 2'd0 : 2'(dp_cmd(f));
            K_EXECI:    begin srcb = 1; alu = (dp_cmd(f) < 0) ? 2'd0 : 2'(dp_cmd(f)); end
            K_ALUWB:    begin rw = ce; pcw = (rd == 4'd15) && ce; end
            K_BRANCH:   begin srcb = 1; res = 2; pcw = ce; end
            default:    ;
        endcase
        if (rst) begin pcw = 0; mw = 0; rw = 0; irw = 0; end
        return {pcw, mw, rw, irw, adr, res, srca, srcb, alu, op, op == 2'b01, op == 2'b10};
    endfunction

    // Flags change only after an executed S-suffixed supported DP op.
    task automatic model_flags(input kind_t k, input logic [3:0] c, input logic [5:0] f,
                               input logic [3:0] af);
        int cmd = dp_cmd(f);
        if ((k == K_EXECR || k == K_EXECI) && f[0] && cond_ok(c, m_flags) && cmd >= 0) begin
            m_flags[3:2] = af[3:2];
            if (cmd <= 1) m_flags[1:0] = af[1:0];
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input int af);
        Cond = c; Op = op; Funct = f; Rd = rd;
        ALUFlags = (af < 0) ? 4'($urandom) : 4'(af);
    endtask

    // One whole instruction from step 'start'; af<0 means random ALUFlags each cycle.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input int af, input int start);
        kind_t k;
        for (int i = start; i < latency(op, f); i++) begin
            @(negedge clk);
            drive(c, op, f, rd, af);
            #1;
            k = step_of(op, f, i);
            check($sformatf("c%h op%h f%b rd%h step%0d", c, op, f, rd, i), w_got,
                  exp_outputs(k, c, op, f, rd, m_flags, 1'b0));
            model_flags(k, c, f, ALUFlags);
        end
    endtask

    // Release reset at a falling edge; the FETCH of the given instruction is visible at once.
    task automatic release_reset(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                                 input logic [3:0] rd, input int af);
        @(negedge clk);
        drive(c, op, f, rd, af);
        reset = 1'b0;
        #1;
        check("release_fetch", w_got, exp_outputs(K_FETCH, c, op, f, rd, m_flags, 1'b0));
        run_instr(c, op, f, rd, af, 1);
    endtask

    initial begin
        logic [3:0] c, rd;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] cmds [4];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;

        m_flags = 4'b0000;
        reset = 1'b1;
        drive(4'hE, 2'b00, 6'b101001, 4'd1, 4);
        #2;
        check("reset_state", w_got, exp_outputs(K_FETCH, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0, 1'b1));
        @(negedge clk); #1;
        check("reset_hold", w_got, exp_outputs(K_FETCH, 4'hE, 2'b00, 6'b101001, 4'd1, 4'b0, 1'b1));

        // ADDS imm, ALUFlags=0100 -> Z set
        release_reset(4'hE, 2'b00, 6'b101001, 4'd1, 4);
        run_instr(4'hE, 2'b01, 6'b011001, 4'd2, -1, 0);   // LDR
        run_instr(4'hE, 2'b00, 6'b000101, 4'd3, 0, 0);    // SUBS -> flags 0000
        run_instr(4'h0, 2'b01, 6'b011000, 4'd4, -1, 0);   // STREQ with Z=0: suppressed
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, -1, 0);   // BNE, Z=0: taken
        run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4, 0);    // ADDS -> Z=1
        run_instr(4'h1, 2'b10, 6'b000000, 4'd0, -1, 0);   // BNE, Z=1: not taken
        run_instr(4'hE, 2'b00, 6'b000100, 4'd15, -1, 0);  // SUB to PC
        run_instr(4'hE, 2'b00, 6'b011111, 4'd5, 0, 0);    // unsupported cmd with S: no flag update
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, -1, 0);   // BEQ: still Z=1
        run_instr(4'hE, 2'b11, 6'b101010, 4'd6, -1, 0);   // Op=11
        run_instr(4'hF, 2'b10, 6'b000000, 4'd0, -1, 0);   // NV branch never executes
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 15, 0);   // ADDS reg -> flags 1111

        // Reset asserted part-way through EXECR
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'hE, 2'b00, 6'b001001, 4'd7, -1);
            #1;
            check($sformatf("pre_reset step%0d", i), w_got,
                  exp_outputs(step_of(2'b00, 6'b001001, i), 4'hE, 2'b00, 6'b001001, 4'd7, m_flags, 1'b0));
        end
        #1 reset = 1'b1;
        m_flags = 4'b0000;
        #1;
        check("reset_mid_execr", w_got, exp_outputs(K_FETCH, 4'hE, 2'b00, 6'b001001, 4'd7, m_flags, 1'b1));
        @(negedge clk); #1;
        check("reset_mid_hold", w_got, exp_outputs(K_FETCH, 4'hE, 2'b00, 6'b001001, 4'd7, m_flags, 1'b1));
        release_reset(4'h0, 2'b10, 6'b000000, 4'd0, -1); // BEQ: flags cleared so not taken

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            c  = 4'($urandom);
            op = 2'($urandom);
            f  = 6'($urandom);
            if ($urandom_range(0, 3) != 0) f[4:1] = cmds[$urandom_range(0, 3)];
            rd = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
            run_instr(c, op, f, rd, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
